// File: rtl/decision_seq.sv
// Sequencer that issues each stored (x1,x2,x3) triple to the decision classifier and records the class codes.
// Per vector: ISSUE until y_valid_i or TIMEOUT cycles elapse, then one GAP cycle with start_o low.
module decision_seq #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 15,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [7:0]    load_x1_i,
  input  logic [7:0]    load_x2_i,
  input  logic [7:0]    load_x3_i,
  input  logic          run_i,
  output logic [7:0]    x1_o,
  output logic [7:0]    x2_o,
  output logic [7:0]    x3_o,
  output logic          start_o,
  input  logic [7:0]    y_i,
  input  logic          y_valid_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    result_o,
  output logic [CW-1:0] cnt_y1_o,
  output logic [CW-1:0] cnt_y2_o,
  output logic [CW-1:0] cnt_y3_o,
  output logic [CW-1:0] cnt_y4_o,
  output logic [CW-1:0] err_cnt_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    vec_x1 [DEPTH];
  logic [7:0]    vec_x2 [DEPTH];
  logic [7:0]    vec_x3 [DEPTH];
  logic [7:0]    result [DEPTH];
  logic [CW-1:0] cnt_y  [4];
  logic [CW-1:0] err_cnt;

  assign result_o  = result[rd_addr_i];
  assign cnt_y1_o  = cnt_y[0];
  assign cnt_y2_o  = cnt_y[1];
  assign cnt_y3_o  = cnt_y[2];
  assign cnt_y4_o  = cnt_y[3];
  assign err_cnt_o = err_cnt;

  // The vector table survives reset so a pass can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (load_en_i && !busy_o) begin
      vec_x1[load_addr_i] <= load_x1_i;
      vec_x2[load_addr_i] <= load_x2_i;
      vec_x3[load_addr_i] <= load_x3_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      start_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      x1_o      <= '0;
      x2_o      <= '0;
      x3_o      <= '0;
      err_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) result[i] <= 8'h00;
      for (int k = 0; k < 4; k++) cnt_y[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (run_i) begin
            state     <= ISSUE;
            idx       <= '0;
            wait_cnt  <= '0;
            start_o   <= 1'b1;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            x1_o      <= vec_x1[0];
            x2_o      <= vec_x2[0];
            x3_o      <= vec_x3[0];
            err_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) result[i] <= 8'h00;
            for (int k = 0; k < 4; k++) cnt_y[k] <= '0;
          end
        end
        ISSUE: begin
          // A response arriving on the last wait cycle still beats the timeout.
          if (y_valid_i) begin
            result[idx] <= y_i;
            case (y_i)
              8'h01, 8'h02, 8'h03, 8'h04:
                cnt_y[2'(y_i - 8'd1)] <= cnt_y[2'(y_i - 8'd1)] + 1'b1;
              default: err_cnt <= err_cnt + 1'b1;
            endcase
            start_o <= 1'b0;
            state   <= GAP;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            result[idx] <= 8'hFF;
            err_cnt     <= err_cnt + 1'b1;
            timeout_o   <= 1'b1;
            start_o     <= 1'b0;
            state       <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          wait_cnt <= '0;
          if (idx == AW'(DEPTH - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            idx     <= idx + 1'b1;
            x1_o    <= vec_x1[idx + 1'b1];
            x2_o    <= vec_x2[idx + 1'b1];
            x3_o    <= vec_x3[idx + 1'b1];
            start_o <= 1'b1;
            state   <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decision_seq.sv
// Bench for decision_seq: a responder answers each issued vector after a chosen latency with a chosen code,
// and a pass-level model predicts results, tallies, issue lengths and done timing.
module tb_decision_seq;
  localparam int DEPTH = 4, AW = 2, TIMEOUT = 15, CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_x1 = '0, load_x2 = '0, load_x3 = '0;
  logic          run = 1'b0;
  logic [7:0]    x1, x2, x3;
  logic          start;
  logic [7:0]    y = '0;
  logic          y_valid = 1'b0;
  logic          busy, done, tmo;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    result;
  logic [CW-1:0] cnt_o [4];
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  decision_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .load_en_i(load_en), .load_addr_i(load_addr),
    .load_x1_i(load_x1), .load_x2_i(load_x2), .load_x3_i(load_x3),
    .run_i(run), .x1_o(x1), .x2_o(x2), .x3_o(x3), .start_o(start),
    .y_i(y), .y_valid_i(y_valid),
    .busy_o(busy), .done_o(done), .timeout_o(tmo),
    .rd_addr_i(rd_addr), .result_o(result),
    .cnt_y1_o(cnt_o[0]), .cnt_y2_o(cnt_o[1]), .cnt_y3_o(cnt_o[2]), .cnt_y4_o(cnt_o[3]),
    .err_cnt_o(err_cnt)
  );

  int n_checks = 0, n_pass = 0;

  // Stimulus configuration and model expectations
  logic [23:0] vec_m [DEPTH];
  int          lat   [DEPTH];   // response cycle within ISSUE (1 = first); outside 1..TIMEOUT means silent
  logic [7:0]  code  [DEPTH];
  logic [7:0]  exp_res [DEPTH];
  int          exp_len [DEPTH];
  int          exp_cnt [4];
  int          exp_err, exp_done;
  bit          exp_to;

  // Monitor / responder observations
  int          tick = 0, cur = -1, clen = 0, low_run = 0;
  int          done_rises = 0, done_tick = -1, run_tick = -1;
  int          olen [DEPTH];
  int          ogap [DEPTH];
  logic [23:0] ox   [DEPTH];
  bit          xbad = 0, ovf = 0, noise_en = 1;
  logic        prev_start = 1'b0, prev_done = 1'b0;

  function automatic void model();
    exp_err = 0; exp_to = 0; exp_done = 1;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lat[i] >= 1 && lat[i] <= TIMEOUT) begin
        exp_res[i] = code[i];
        exp_len[i] = lat[i];
        if (code[i] >= 8'd1 && code[i] <= 8'd4) exp_cnt[int'(code[i]) - 1]++;
        else exp_err++;
      end else begin
        exp_res[i] = 8'hFF;
        exp_len[i] = TIMEOUT;
        exp_err++;
        exp_to = 1;
      end
      exp_done += exp_len[i] + 1;
    end
  endfunction

  // Sample just after each rising edge; answer during ISSUE, inject ignored y_valid noise elsewhere.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick++;
      if (run === 1'b1 && run_tick < 0) run_tick = tick;
      if (done === 1'b1 && prev_done !== 1'b1) begin done_rises++; done_tick = tick; end
      if (start === 1'b1) begin
        if (prev_start !== 1'b1) begin
          if (cur < DEPTH - 1) begin
            if (cur >= 0) ogap[cur] = low_run;
            cur++;
          end else ovf = 1;
          clen = 0;
          ox[cur] = {x1, x2, x3};
        end else if ({x1, x2, x3} !== ox[cur]) xbad = 1;
        clen++;
        olen[cur] = clen;
        y_valid = (cur >= 0 && clen == lat[cur]);
        y = y_valid ? code[cur] : 8'($urandom);
        low_run = 0;
      end else begin
        low_run++;
        y_valid = noise_en && ($urandom_range(0, 3) == 0);
        y = 8'($urandom);
      end
      prev_start = start;
      prev_done = done;
    end
  end

  task automatic mon_clear();
    cur = -1; low_run = 0; done_rises = 0; done_tick = -1; run_tick = -1; xbad = 0; ovf = 0;
    for (int i = 0; i < DEPTH; i++) begin olen[i] = 0; ogap[i] = 0; ox[i] = '0; end
  endtask

  task automatic load_vec(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(i); load_x1 = a; load_x2 = b; load_x3 = c;
    @(negedge clk);
    load_en = 1'b0;
    vec_m[i] = {a, b, c};
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++)
      load_vec(i, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic pulse_run();
    mon_clear();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_cur(input int target, output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cur == target) begin ok = 1; break; end
    end
  endtask

  task automatic normal_cfg();
    for (int i = 0; i < DEPTH; i++) begin lat[i] = 3; code[i] = 8'(i + 1); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({start, busy, done, tmo} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {start, busy, done, tmo}); else n_pass++;
    n_checks++; if ({x1, x2, x3} !== 24'h0) $display("FAIL reset_x got %h want 000000", {x1, x2, x3}); else n_pass++;
    n_checks++; if ({cnt_o[0], cnt_o[1], cnt_o[2], cnt_o[3], err_cnt} !== '0) $display("FAIL reset_counts got nonzero want 0"); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== 8'h00) $display("FAIL reset_res[%0d] got %h want 00", i, result); else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    bit ok;
    load_vec(0, 8'h80, 8'h80, 8'h80);
    load_vec(1, 8'h08, 8'h80, 8'h01);
    load_vec(2, 8'h08, 8'h01, 8'h01);
    load_vec(3, 8'h01, 8'h01, 8'h01);
    normal_cfg(); model();
    pulse_run();
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL normal_busy got busy=%b done=%b want 1/0", busy, done); else n_pass++;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL normal_done_wait got no done want done"); else n_pass++;
    n_checks++; if (done_tick - (run_tick - 1) != 17) $display("FAIL normal_done_time got %0d want 17", done_tick - (run_tick - 1)); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== exp_res[i]) $display("FAIL normal_res[%0d] got %h want %h", i, result, exp_res[i]); else n_pass++;
      n_checks++; if (ox[i] !== vec_m[i]) $display("FAIL normal_x[%0d] got %h want %h", i, ox[i], vec_m[i]); else n_pass++;
      n_checks++; if (olen[i] != 3) $display("FAIL normal_len[%0d] got %0d want 3", i, olen[i]); else n_pass++;
      n_checks++; if (cnt_o[i] !== CW'(1)) $display("FAIL normal_cnt%0d got %0d want 1", i + 1, cnt_o[i]); else n_pass++;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      n_checks++; if (ogap[i] != 1) $display("FAIL normal_gap[%0d] got %0d want 1", i, ogap[i]); else n_pass++;
    end
    n_checks++; if (err_cnt !== '0 || tmo !== 1'b0) $display("FAIL normal_err got err=%0d to=%b want 0/0", err_cnt, tmo); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || start !== 1'b0) $display("FAIL normal_hold got d/b/s=%b%b%b want 100", done, busy, start); else n_pass++;
    n_checks++; if (xbad || ovf) $display("FAIL normal_issue got xbad=%0d ovf=%0d want 0/0", xbad, ovf); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin lat[i] = 6; code[i] = 8'(i + 1); end
    pulse_run();
    wait_cur(1, ok);
    n_checks++; if (!ok) $display("FAIL rstmid_reach got no entry 1 want entry 1"); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if ({start, busy, done, tmo} !== 4'b0000) $display("FAIL rstmid_flags got %b want 0000", {start, busy, done, tmo}); else n_pass++;
    n_checks++; if ({cnt_o[0], cnt_o[1], cnt_o[2], cnt_o[3], err_cnt} !== '0) $display("FAIL rstmid_counts got nonzero want 0"); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== 8'h00) $display("FAIL rstmid_res[%0d] got %h want 00", i, result); else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++; if (start !== 1'b0) $display("FAIL rstmid_idle got start=%b want 0", start); else n_pass++;
    normal_cfg(); model();
    pulse_run();
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL rstmid_rerun got no done want done"); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== exp_res[i]) $display("FAIL rstmid_rerun_res[%0d] got %h want %h", i, result, exp_res[i]); else n_pass++;
      n_checks++; if (ox[i] !== vec_m[i]) $display("FAIL rstmid_rerun_x[%0d] got %h want %h", i, ox[i], vec_m[i]); else n_pass++;
    end
  endtask

  task automatic test_busy();
    bit ok;
    normal_cfg(); model();
    pulse_run();
    wait_cur(1, ok);
    load_en = 1'b1; load_addr = AW'(3); load_x1 = 8'hAA; load_x2 = 8'hAA; load_x3 = 8'hAA;
    run = 1'b1;
    @(negedge clk);
    load_en = 1'b0; run = 1'b0;
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL busy_done got no done want done"); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++; if (ox[3] !== 24'h010101) $display("FAIL busy_load got %h want 010101", ox[3]); else n_pass++;
    n_checks++; if (done_rises != 1) $display("FAIL busy_done_rises got %0d want 1", done_rises); else n_pass++;
    n_checks++; if (done_tick - (run_tick - 1) != exp_done) $display("FAIL busy_done_time got %0d want %0d", done_tick - (run_tick - 1), exp_done); else n_pass++;
    rd_addr = AW'(3); #1;
    n_checks++; if (result !== 8'h04) $display("FAIL busy_res3 got %h want 04", result); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    load_random();
    for (int i = 0; i < DEPTH; i++) begin lat[i] = $urandom_range(1, 10); code[i] = 8'($urandom_range(1, 4)); end
    lat[2] = 0;
    model();
    pulse_run();
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL timeout_done got no done want done"); else n_pass++;
    n_checks++; if (olen[2] != TIMEOUT) $display("FAIL timeout_len got %0d want %0d", olen[2], TIMEOUT); else n_pass++;
    n_checks++; if (err_cnt !== CW'(1) || tmo !== 1'b1) $display("FAIL timeout_err got err=%0d to=%b want 1/1", err_cnt, tmo); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== exp_res[i]) $display("FAIL timeout_res[%0d] got %h want %h", i, result, exp_res[i]); else n_pass++;
      n_checks++; if (cnt_o[i] !== CW'(exp_cnt[i])) $display("FAIL timeout_cnt%0d got %0d want %0d", i + 1, cnt_o[i], exp_cnt[i]); else n_pass++;
      n_checks++; if (ox[i] !== vec_m[i]) $display("FAIL timeout_x[%0d] got %h want %h", i, ox[i], vec_m[i]); else n_pass++;
    end
  endtask

  task automatic test_invalid();
    bit ok;
    for (int i = 0; i < DEPTH; i++) lat[i] = $urandom_range(1, 10);
    code[0] = 8'h07; code[1] = 8'h02; code[2] = 8'h03; code[3] = 8'h00;
    model();
    pulse_run();
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL invalid_done got no done want done"); else n_pass++;
    n_checks++; if (err_cnt !== CW'(2) || tmo !== 1'b0) $display("FAIL invalid_err got err=%0d to=%b want 2/0", err_cnt, tmo); else n_pass++;
    n_checks++; if (cnt_o[1] !== CW'(1) || cnt_o[2] !== CW'(1)) $display("FAIL invalid_cnt got y2=%0d y3=%0d want 1/1", cnt_o[1], cnt_o[2]); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); #1;
      n_checks++; if (result !== exp_res[i]) $display("FAIL invalid_res[%0d] got %h want %h", i, result, exp_res[i]); else n_pass++;
    end
  endtask

  task automatic test_valid_on_timeout();
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin lat[i] = $urandom_range(1, 6); code[i] = 8'($urandom_range(1, 4)); end
    lat[1] = TIMEOUT; code[1] = 8'h04;
    model();
    pulse_run();
    wait_done(ok);
    n_checks++; if (!ok) $display("FAIL vot_done got no done want done"); else n_pass++;
    rd_addr = AW'(1); #1;
    n_checks++; if (result !== 8'h04) $display("FAIL vot_res got %h want 04", result); else n_pass++;
    n_checks++; if (cnt_o[3] !== CW'(exp_cnt[3])) $display("FAIL vot_cnt4 got %0d want %0d", cnt_o[3], exp_cnt[3]); else n_pass++;
    n_checks++; if (tmo !== 1'b0 || err_cnt !== '0) $display("FAIL vot_flags got to=%b err=%0d want 0/0", tmo, err_cnt); else n_pass++;
    n_checks++; if (olen[1] != TIMEOUT) $display("FAIL vot_len got %0d want %0d", olen[1], TIMEOUT); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    for (int p = 0; p < 4; p++) begin
      load_random();
      for (int i = 0; i < DEPTH; i++) begin
        lat[i] = $urandom_range(0, TIMEOUT + 2);
        code[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
      end
      model();
      pulse_run();
      wait_done(ok);
      n_checks++; if (!ok) $display("FAIL rand%0d_done got no done want done", p); else n_pass++;
      n_checks++; if (done_tick - (run_tick - 1) != exp_done) $display("FAIL rand%0d_time got %0d want %0d", p, done_tick - (run_tick - 1), exp_done); else n_pass++;
      n_checks++; if (err_cnt !== CW'(exp_err) || tmo !== exp_to) $display("FAIL rand%0d_err got err=%0d to=%b want %0d/%0d", p, err_cnt, tmo, exp_err, exp_to); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
        rd_addr = AW'(i); #1;
        n_checks++; if (result !== exp_res[i]) $display("FAIL rand%0d_res[%0d] got %h want %h", p, i, result, exp_res[i]); else n_pass++;
        n_checks++; if (cnt_o[i] !== CW'(exp_cnt[i])) $display("FAIL rand%0d_cnt%0d got %0d want %0d", p, i + 1, cnt_o[i], exp_cnt[i]); else n_pass++;
        n_checks++; if (olen[i] != exp_len[i] || ox[i] !== vec_m[i]) $display("FAIL rand%0d_issue[%0d] got len=%0d x=%h want %0d/%h", p, i, olen[i], ox[i], exp_len[i], vec_m[i]); else n_pass++;
      end
      n_checks++; if (xbad || ovf) $display("FAIL rand%0d_stable got xbad=%0d ovf=%0d want 0/0", p, xbad, ovf); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_reset_mid();
    test_busy();
    test_timeout();
    test_invalid();
    test_valid_on_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decision_seq.md
Name: decision_seq

Overview:
- Initiator/sequencer for the decision classifier. Holds a small table of (x1, x2, x3) input triples, issues each to the classifier with a start handshake, and captures the returned class code (Y1..Y4 = 8'h01..8'h04).
- Keeps per-class tallies, an error tally and a result table.
- Sits on the driving side of the classifier's x/start -> y/y_valid interface. Used for on-chip self-test and for batch classification.

Parameters:
- DEPTH, 4, number of vector/result entries (power of 2).
- AW, 2, address width, log2(DEPTH).
- TIMEOUT, 15, max cycles to wait for y_valid_i per vector before declaring a timeout.
- CW, 3, tally counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en_i  in  1  write one vector entry this cycle.
- load_addr_i  in  AW  vector entry to write.
- load_x1_i / load_x2_i / load_x3_i  in  8 each  vector data to write.
- run_i  in  1  start a pass over all DEPTH entries.
- x1_o / x2_o / x3_o  out  8 each  current vector to classifier.
- start_o  out  1  request to classifier.
- y_i  in  8  class code from classifier.
- y_valid_i  in  1  y_i valid.
- busy_o  out  1  pass in progress.
- done_o  out  1  pass complete; held high until next run_i or reset.
- timeout_o  out  1  sticky: at least one vector timed out this pass.
- rd_addr_i  in  AW  result table read address.
- result_o  out  8  result entry at rd_addr_i; combinational read.
- cnt_y1_o .. cnt_y4_o  out  CW each  count of results 01..04.
- err_cnt_o  out  CW  count of invalid codes plus timeouts.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, idx=0.
  - start_o=0, busy_o=0, done_o=0, timeout_o=0.
  - All counters 0; all result entries 8'h00; x*_o=0.
  - Vector table is NOT cleared.
  - Reset mid-pass aborts immediately; start_o is low from the next cycle.
- Vector load: accepted only when busy_o=0. load_en_i while busy_o=1 is ignored. A written entry is readable by a pass starting the next cycle.
- IDLE / DONE:
  - run_i=1 clears all counters, results and timeout_o, and sets idx=0.
  - Next state ISSUE; busy_o=1 and done_o=0 from the next cycle.
  - run_i while in ISSUE or GAP is ignored.
- ISSUE:
  - start_o=1; x*_o = vector[idx], held stable for the whole state. Wait counter increments each cycle.
  - y_valid_i=1 sampled: result[idx] <= y_i.
    - y_i in 01..04 increments the matching cnt_yN.
    - Any other value increments err_cnt.
    - Next state GAP.
  - Wait counter reaches TIMEOUT with y_valid_i=0: result[idx] <= 8'hFF, err_cnt+1, timeout_o<=1, next state GAP.
  - If y_valid_i=1 on the timeout cycle, valid wins and no timeout is recorded.
  - Minimum response latency: y_valid_i in the first ISSUE cycle is accepted (1 cycle).
- GAP:
  - Exactly one cycle with start_o=0; wait counter cleared.
  - If idx=DEPTH-1: next state DONE, done_o=1, busy_o=0, start_o=0.
  - Otherwise idx+1 and return to ISSUE.
- y_valid_i outside ISSUE is ignored.
- Counters never wrap within a pass, since DEPTH < 2^CW.
- x*_o hold their last value outside ISSUE.

Test Plan:
- Normal pass:
  - Stimulus: load vectors {80,80,80}, {08,80,01}, {08,01,01}, {01,01,01}; run_i pulse; responder model returns 01, 02, 03, 04 with y_valid 3 cycles after start rises.
  - Required: results 01/02/03/04; each cnt_yN=1; err=0.
  - Required: start_o drops for exactly 1 cycle between vectors; done_o rises 4*(3+1)+1 cycles after run_i.
- Timeout:
  - Stimulus: responder silent on entry 2.
  - Required: start_o held exactly TIMEOUT=15 cycles; result[2]=FF; err_cnt=1; timeout_o=1; other entries correct; pass still completes.
- Invalid code:
  - Stimulus: responder returns 8'h07 for entry 0 and 8'h00 for entry 3.
  - Required: those results are 07 and 00; err_cnt=2; cnt_y2=1; cnt_y3=1; timeout_o=0.
- Valid on timeout cycle:
  - Stimulus: y_valid_i=1 with y=04 on the 15th wait cycle.
  - Required: result=04; cnt_y4+1; timeout_o=0.
- Reset mid-pass:
  - Stimulus: reset during ISSUE of entry 1.
  - Required: next cycle start_o=0, busy_o=0, all counts/results 0.
  - Required: a new run_i reuses the previously loaded vectors and reproduces the normal-pass results.
- Busy protection:
  - Stimulus: load_en_i writing entry 3 := {AA,AA,AA} and a second run_i, both during a pass.
  - Required: both ignored; entry 3 is issued as {01,01,01}; exactly one done_o rise.
